// File: rtl/controlador_pid_param.sv
// Fixed-point PID controller, one sample every five clocks.
// Sequence per sample: capture error -> P term -> I term -> D term -> sum/clamp.
// All data ports are signed Q(N-F).F. The setpoint port is ref_i because "ref"
// is a reserved word in SystemVerilog.
module controlador_pid_param #(
   parameter int N       = 16,
   parameter int F       = 8,
   parameter int OUT_MAX = (2**(N-1)) - 1,
   parameter int OUT_MIN = -(2**(N-1))
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                datolisto,
   input  logic signed [N-1:0] yk,
   input  logic signed [N-1:0] ref_i,
   input  logic signed [N-1:0] kp,
   input  logic signed [N-1:0] ki,
   input  logic signed [N-1:0] kd,
   input  logic                en_integral,
   input  logic                clr_integral,
   output logic signed [N-1:0] resultado,
   output logic                operacionlisto,
   output logic                ocupado
);

   // Working width: holds a full 2N-bit product plus headroom for one more add.
   localparam int XW = 2*N + 2;
   localparam logic signed [N-1:0] OMAX = N'(OUT_MAX);
   localparam logic signed [N-1:0] OMIN = N'(OUT_MIN);

   typedef enum logic [2:0] {IDLE, P, I, D, S} state_t;

   state_t                state_q;
   logic signed [N-1:0]   ek_q, ekprev_q;
   logic signed [N-1:0]   kp_q, ki_q, kd_q;
   logic signed [N-1:0]   pk_q, ik_q, dk_q;
   logic signed [N-1:0]   resultado_q;
   logic                  oplisto_q;

   logic signed [N-1:0]   ek_d, pk_d, ik_d, dk_d, res_d, ediff;
   logic signed [XW-1:0]  iterm;
   logic                  aw_block;

   // Saturate a wide signed value to the N-bit range: in range iff all bits
   // above N-2 agree with the sign.
   function automatic logic signed [N-1:0] sat_n(input logic signed [XW-1:0] x);
      logic hi_any;
      logic hi_all;
      hi_any = |x[XW-2:N-1];
      hi_all = &x[XW-2:N-1];
      if (!x[XW-1] && hi_any)
         sat_n = {1'b0, {(N-1){1'b1}}};
      else if (x[XW-1] && !hi_all)
         sat_n = {1'b1, {(N-1){1'b0}}};
      else
         sat_n = x[N-1:0];
   endfunction

   // Clamp to the configured output window.
   function automatic logic signed [N-1:0] clamp_out(input logic signed [N-1:0] v);
      if (v > OMAX)
         clamp_out = OMAX;
      else if (v < OMIN)
         clamp_out = OMIN;
      else
         clamp_out = v;
   endfunction

   // Next values for every stage; the FSM decides which one is committed.
   always_comb begin
      ek_d     = sat_n(XW'(ref_i) - XW'(yk));
      pk_d     = sat_n((XW'(kp_q) * XW'(ek_q)) >>> F);
      iterm    = (XW'(ki_q) * XW'(ek_q)) >>> F;
      // Stop winding further into a rail the output is already pinned at.
      aw_block = ((resultado_q == OMAX) && !iterm[XW-1] && (|iterm)) ||
                 ((resultado_q == OMIN) && iterm[XW-1]);
      ik_d     = (en_integral && !aw_block) ? sat_n(XW'(ik_q) + iterm) : ik_q;
      ediff    = sat_n(XW'(ek_q) - XW'(ekprev_q));
      dk_d     = sat_n((XW'(kd_q) * XW'(ediff)) >>> F);
      res_d    = clamp_out(sat_n(XW'(pk_q) + XW'(ik_q) + XW'(dk_q)));
   end

   // Sequencer and all datapath registers; integrator clear overrides any stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ek_q        <= '0;
         ekprev_q    <= '0;
         kp_q        <= '0;
         ki_q        <= '0;
         kd_q        <= '0;
         pk_q        <= '0;
         ik_q        <= '0;
         dk_q        <= '0;
         resultado_q <= '0;
         oplisto_q   <= 1'b0;
      end else begin
         oplisto_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (datolisto) begin
                  ek_q    <= ek_d;
                  kp_q    <= kp;
                  ki_q    <= ki;
                  kd_q    <= kd;
                  state_q <= P;
               end
            end
            P: begin
               pk_q    <= pk_d;
               state_q <= I;
            end
            I: begin
               ik_q    <= ik_d;
               state_q <= D;
            end
            D: begin
               dk_q     <= dk_d;
               ekprev_q <= ek_q;
               state_q  <= S;
            end
            S: begin
               resultado_q <= res_d;
               oplisto_q   <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
         if (clr_integral) begin
            ik_q     <= '0;
            ekprev_q <= '0;
         end
      end
   end

   assign resultado      = resultado_q;
   assign operacionlisto = oplisto_q;
   assign ocupado        = (state_q != IDLE);

endmodule

// File: tb/tb_controlador_pid_param.sv
// Scoreboard bench for controlador_pid_param (N=16, F=8, output window
// [-12000, 10000]). The driver predicts each result from a behavioural model
// and queues it; an independent monitor checks every operacionlisto pulse.
module tb_controlador_pid_param;

   localparam int N    = 16;
   localparam int F    = 8;
   localparam int OMAX = 10000;
   localparam int OMIN = -12000;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                datolisto = 1'b0;
   logic                en_integral = 1'b0;
   logic                clr_integral = 1'b0;
   logic signed [N-1:0] yk = '0;
   logic signed [N-1:0] ref_v = '0;
   logic signed [N-1:0] kp = '0;
   logic signed [N-1:0] ki = '0;
   logic signed [N-1:0] kd = '0;
   logic signed [N-1:0] resultado;
   logic                operacionlisto;
   logic                ocupado;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      longint val;
      int     at;
   } exp_t;
   exp_t sbq[$];

   // Reference model state
   longint m_ik = 0;
   longint m_ep = 0;
   longint m_res = 0;

   controlador_pid_param #(
      .N(N), .F(F), .OUT_MAX(OMAX), .OUT_MIN(OMIN)
   ) dut (
      .clk(clk), .reset(reset), .datolisto(datolisto),
      .yk(yk), .ref_i(ref_v), .kp(kp), .ki(ki), .kd(kd),
      .en_integral(en_integral), .clr_integral(clr_integral),
      .resultado(resultado), .operacionlisto(operacionlisto), .ocupado(ocupado)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic longint sat(input longint x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   // One full controller update, straight from the arithmetic rules.
   function automatic longint model(input longint y, input longint r, input longint pg,
                                    input longint ig, input longint dg,
                                    input bit en, input bit clr_i);
      longint e, p, t, d, tot;
      e = sat(r - y);
      p = sat((pg * e) >>> F);
      t = (ig * e) >>> F;
      if (clr_i) begin
         m_ik = 0;
         m_ep = 0;
      end else if (en && !((m_res == OMAX && t > 0) || (m_res == OMIN && t < 0))) begin
         m_ik = sat(m_ik + t);
      end
      d    = sat((dg * sat(e - m_ep)) >>> F);
      m_ep = e;
      tot  = sat(p + m_ik + d);
      m_res = (tot > OMAX) ? OMAX : ((tot < OMIN) ? OMIN : tot);
      return m_res;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int rnd16();
      logic signed [15:0] s;
      s = 16'($urandom());
      return int'(s);
   endfunction

   // Monitor: every pulse must match the head of the queue; otherwise output must hold.
   initial begin : monitor
      exp_t   e;
      longint last;
      last = 0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            last = 0;
         end else if (operacionlisto) begin
            if (sbq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL spurious_pulse: operacionlisto=1 with no pending sample (cycle %0d)", cyc);
            end else begin
               e = sbq.pop_front();
               check("resultado", resultado, e.val);
               check("latency", cyc, e.at);
               last = e.val;
            end
         end else begin
            check("hold", resultado, last);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   // Issue one accepted sample (called at a negedge) and track ocupado over it.
   task automatic send(input int y, input int r, input int pg, input int ig, input int dg,
                       input bit en, input bit clr_i);
      exp_t e;
      yk = 16'(y); ref_v = 16'(r); kp = 16'(pg); ki = 16'(ig); kd = 16'(dg);
      en_integral = en;
      datolisto = 1'b1;
      e.val = model(y, r, pg, ig, dg, en, clr_i);
      e.at  = cyc + 5;
      sbq.push_back(e);
      @(negedge clk);
      datolisto = 1'b0;
      for (int n = 1; n <= 4; n++) begin
         if (n > 1) @(negedge clk);
         check("ocupado_busy", ocupado, 1);
         clr_integral = (clr_i && n == 2);
      end
      @(negedge clk);
      clr_integral = 1'b0;
      check("ocupado_idle", ocupado, 0);
   endtask

   task automatic clear_int();
      clr_integral = 1'b1;
      @(negedge clk);
      clr_integral = 1'b0;
      m_ik = 0;
      m_ep = 0;
   endtask

   initial begin : driver
      exp_t e;
      #12;
      check("rst_resultado", resultado, 0);
      check("rst_operacionlisto", operacionlisto, 0);
      check("rst_ocupado", ocupado, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Proportional only
      send(256, 512, 256, 0, 0, 1, 0);

      // Integral accumulation and hold
      clear_int();
      repeat (3) send(0, 256, 0, 128, 0, 1, 0);
      send(0, 256, 0, 128, 0, 0, 0);

      // Derivative
      clear_int();
      repeat (2) send(0, 256, 0, 0, 256, 1, 0);

      // Output clamp and anti-windup at both rails
      clear_int();
      send(-32768, 32767, 32512, 0, 0, 1, 0);
      repeat (3) send(-32768, 32767, 32512, 128, 0, 1, 0);
      repeat (3) send(32767, -32768, 32512, 128, 0, 1, 0);

      // Clear landing on the integrator stage
      send(0, 1000, 100, 50, 200, 1, 0);
      send(0, 1000, 100, 50, 200, 1, 1);

      // Second strobe while busy is ignored; next strobe right after is taken
      yk = 16'(0); ref_v = 16'(256); kp = 16'(256); ki = '0; kd = '0; en_integral = 1'b1;
      datolisto = 1'b1;
      e.val = model(0, 256, 256, 0, 0, 1, 0);
      e.at  = cyc + 5;
      sbq.push_back(e);
      @(negedge clk);
      datolisto = 1'b0;
      @(negedge clk);
      yk = -16'sd5000; ref_v = 16'sd5000; kp = 16'sd1000; datolisto = 1'b1;
      @(negedge clk);
      datolisto = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("busy_strobe_ignored", ocupado, 0);
      send(0, 300, 256, 0, 0, 1, 0);

      // Reset in the middle of a computation
      send(0, 700, 256, 0, 256, 1, 0);
      yk = '0; ref_v = 16'sd900; kp = 16'sd256; kd = 16'sd256; datolisto = 1'b1;
      @(negedge clk);
      datolisto = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("abort_resultado", resultado, 0);
      check("abort_ocupado", ocupado, 0);
      check("abort_operacionlisto", operacionlisto, 0);
      m_ik = 0; m_ep = 0; m_res = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      send(0, 256, 0, 0, 256, 1, 0);

      // Randomized samples
      for (int t = 0; t < 60; t++) begin
         int y, r, pg, ig, dg;
         y = rnd16();
         r = rnd16();
         if ($urandom_range(0, 1) == 1) begin
            pg = $urandom_range(0, 1024) - 512;
            ig = $urandom_range(0, 256) - 128;
            dg = $urandom_range(0, 1024) - 512;
         end else begin
            pg = rnd16();
            ig = rnd16();
            dg = rnd16();
         end
         if ($urandom_range(0, 7) == 0) clear_int();
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         send(y, r, pg, ig, dg, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
      end

      repeat (3) @(negedge clk);
      check("pending_outputs", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/controlador_pid_param.md
CONTROLADOR_PID_PARAM -- requirements
Module: controlador_pid_param

Interface
REQ-001 Parameter N, default 16: signed two's-complement word width of every data port.
REQ-002 Parameter F, default 8: fractional bits of the Q(N-F).F fixed-point format on all data ports.
REQ-003 Parameter OUT_MAX, default 2^(N-1)-1: upper clamp of resultado.
REQ-004 Parameter OUT_MIN, default -2^(N-1): lower clamp of resultado; OUT_MIN < OUT_MAX.
REQ-005 Port clk, input, 1: single clock, rising edge active.
REQ-006 Port reset, input, 1: one clock; reset is asynchronous and active-high.
REQ-007 Port datolisto, input, 1: new-sample strobe.
REQ-008 Port yk, input, N signed: plant measurement.
REQ-009 Port ref, input, N signed: setpoint.
REQ-010 Port kp, input, N signed: proportional gain.
REQ-011 Port ki, input, N signed: integral gain.
REQ-012 Port kd, input, N signed: derivative gain.
REQ-013 Port en_integral, input, 1: 1 = integrator updates, 0 = integrator holds.
REQ-014 Port clr_integral, input, 1: synchronous clear of the integrator and the previous-error register.
REQ-015 Port resultado, output, N signed: registered controller output.
REQ-016 Port operacionlisto, output, 1: one-cycle pulse marking a new resultado.
REQ-017 Port ocupado, output, 1: high while a computation is in progress.

Function
REQ-018 FSM states: IDLE, P, I, D, S; ocupado SHALL be 1 exactly when state != IDLE.
REQ-019 IDLE with datolisto=1 at edge k: capture ek = sat(ref - yk) computed in N+1 bits; latch kp, ki, kd; go to P.
REQ-020 P at edge k+1: pk = sat((kp*ek) >>> F); go to I.
REQ-021 I at edge k+2: if en_integral=1 and anti-windup does not block, ik = sat(ik + ((ki*ek) >>> F)); otherwise ik holds; go to D.
REQ-022 D at edge k+3: dk = sat((kd*sat(ek - ek_prev)) >>> F); ek_prev = ek; go to S.
REQ-023 S at edge k+4: resultado = clamp(sat(pk+ik+dk), OUT_MIN, OUT_MAX); operacionlisto=1 for that cycle only; go to IDLE.
REQ-024 Latency: resultado and operacionlisto SHALL update at edge k+4; maximum throughput is one sample per 5 clocks; datolisto is accepted again at edge k+5.
REQ-025 datolisto while ocupado=1 SHALL be ignored, with no queueing and no effect on the current computation.
REQ-026 Products SHALL be full 2N-bit; >>> F is an arithmetic shift (floor); sat() SHALL clamp to [-2^(N-1), 2^(N-1)-1].
REQ-027 Anti-windup: the integrator update SHALL be blocked when the previous resultado equals OUT_MAX and the ki*ek term is > 0, or equals OUT_MIN and the term is < 0.
REQ-028 clr_integral=1 SHALL set ik=0 and ek_prev=0 at the next edge, in any state; if it coincides with the I state, the clear SHALL win.
REQ-029 resultado SHALL hold its value between updates.
REQ-030 ek_prev SHALL be 0 for the first sample after reset.

Reset
REQ-031 On reset=1: state=IDLE; ek, pk, ik, dk, ek_prev, latched gains and resultado = 0; operacionlisto=0; ocupado=0; all immediately, without waiting for clk.
REQ-032 Reset mid-computation SHALL abort it, produce no operacionlisto pulse, and leave resultado=0.

Verification (N=16, F=8)
REQ-033 kp=256, ki=kd=0, ref=512, yk=256, datolisto pulsed at edge k -> resultado=256 at edge k+4; operacionlisto high exactly one cycle; ocupado high for 4 cycles.
REQ-034 ki=128, kp=kd=0, ek=256, three samples -> resultado 128, 256, 384; with en_integral=0 on the fourth sample -> 384.
REQ-035 kd=256, kp=ki=0, ek=256 for two consecutive samples -> resultado 256 then 0.
REQ-036 OUT_MAX=10000, kp=32512, ref=32767, yk=-32768 -> ek=32767 and resultado=10000; with ki=128 added, ik SHALL hold from the second sample on (anti-windup).
REQ-037 datolisto pulsed at edges k and k+2 -> exactly one operacionlisto, at edge k+4; datolisto at k+5 accepted, with output at k+9.
REQ-038 reset asserted between edges k+2 and k+3 -> resultado=0, ocupado=0 immediately; no operacionlisto; next sample behaves as the first after reset (ek_prev=0).
